// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit between a core request port and a
// single-word data memory; big-endian lanes, sub-word stores via read-modify-write.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        respValid,
  output logic        respErr,
  output logic [31:0] loadData,
  output logic [31:0] memAdr,
  output logic [31:0] writeData,
  output logic        memWrite,
  input  logic [31:0] readData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  localparam logic [2:0]  F3_B  = 3'b000;
  localparam logic [2:0]  F3_H  = 3'b001;
  localparam logic [2:0]  F3_W  = 3'b010;
  localparam logic [2:0]  F3_BU = 3'b100;
  localparam logic [2:0]  F3_HU = 3'b101;
  localparam logic [32:0] MemLimit = 33'(MEM_BYTES);

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        req_legal;
  logic        req_misaligned;
  logic        req_err;
  logic [2:0]  req_size;
  logic [32:0] req_end;

  // Lane extraction: byte offset 0 is the most significant byte of the word.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_BU:   return {24'b0, b};
      F3_HU:   return {16'b0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3,
                                              input logic [31:0] sd);
    logic [31:0] m;
    m = word;
    case (f3)
      F3_B: begin
        case (off)
          2'd0:    m[31:24] = sd[7:0];
          2'd1:    m[23:16] = sd[7:0];
          2'd2:    m[15:8]  = sd[7:0];
          default: m[7:0]   = sd[7:0];
        endcase
      end
      F3_H: begin
        if (off[1]) m[15:0]  = sd[15:0];
        else        m[31:16] = sd[15:0];
      end
      default: m = sd;
    endcase
    return m;
  endfunction

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    req_legal = 1'b0;
    req_size  = 3'd0;
    if (isStore) begin
      case (funct3)
        F3_B:    begin req_legal = 1'b1; req_size = 3'd1; end
        F3_H:    begin req_legal = 1'b1; req_size = 3'd2; end
        F3_W:    begin req_legal = 1'b1; req_size = 3'd4; end
        default: begin req_legal = 1'b0; req_size = 3'd0; end
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: begin req_legal = 1'b1; req_size = 3'd1; end
        F3_H, F3_HU: begin req_legal = 1'b1; req_size = 3'd2; end
        F3_W:        begin req_legal = 1'b1; req_size = 3'd4; end
        default:     begin req_legal = 1'b0; req_size = 3'd0; end
      endcase
    end
    req_misaligned = ((req_size == 3'd2) && addr[0]) ||
                     ((req_size == 3'd4) && (addr[1:0] != 2'b00));
    // 33-bit sum so an address near 2^32 cannot wrap into range.
    req_end = {1'b0, addr} + {30'b0, req_size};
    req_err = !req_legal || req_misaligned || (req_end > MemLimit);
  end

  assign accept = reqValid && reqReady;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                       state_d = DONE;
          else if (isStore && funct3 == F3_W) state_d = WRITE;
          else                               state_d = READ;
        end
      end
      READ:    state_d = is_store_q ? WRITE : DONE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reqReady  = (state_q == IDLE) && rstN;
    respValid = (state_q == DONE) && rstN;
    memWrite  = (state_q == WRITE) && rstN;
    memAdr    = 32'h0;
    writeData = 32'h0;
    if (state_q == READ || state_q == WRITE) memAdr = {addr_q[31:2], 2'b00};
    if (state_q == WRITE)
      writeData = merge_store(rdata_q, addr_q[1:0], funct3_q, store_data_q);
    respErr  = resp_err_q;
    loadData = load_data_q;
  end

  always_comb begin
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    rdata_d      = rdata_q;
    load_data_d  = load_data_q;
    resp_err_d   = resp_err_q;
    if (accept) begin
      is_store_d   = isStore;
      funct3_d     = funct3;
      addr_d       = addr;
      store_data_d = storeData;
      load_data_d  = 32'h0;
      resp_err_d   = req_err;
    end
    if (state_q == READ) begin
      rdata_d = readData;
      if (!is_store_q) load_data_d = extract_load(readData, addr_q[1:0], funct3_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b0;
      addr_q       <= 32'h0;
      store_data_q <= 32'h0;
      rdata_q      <= 32'h0;
      load_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      rdata_q      <= rdata_d;
      load_data_q  <= load_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver queues expected responses and
// writes, a negedge monitor pops and compares them against a word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic        isStore;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        respValid;
  logic        respErr;
  logic [31:0] loadData;
  logic [31:0] memAdr;
  logic [31:0] writeData;
  logic        memWrite;
  logic [31:0] readData;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(65536)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .isStore   (isStore),
    .funct3    (funct3),
    .addr      (addr),
    .storeData (storeData),
    .respValid (respValid),
    .respErr   (respErr),
    .loadData  (loadData),
    .memAdr    (memAdr),
    .writeData (writeData),
    .memWrite  (memWrite),
    .readData  (readData)
  );

  logic [31:0] mem [0:16383];
  logic        mem_load;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
      mem[14'h0040] <= 32'h8899AABB;
      mem[14'h0042] <= 32'h11223344;
      mem[14'h3FFF] <= 32'hCAFEF00D;
    end else if (memWrite) begin
      mem[memAdr[15:2]] <= writeData;
    end
  end

  assign readData = mem[memAdr[15:2]];

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic        err;
    logic [31:0] data;
    int          lat;
    logic        wr;
    logic [31:0] wd;
  } vec_t;

  resp_t exp_q[$];
  wr_t   wexp_q[$];
  int    acc_q[$];
  int    cycle = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cycle);
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic err, input logic [31:0] data,
                              input int lat, input logic wr, input logic [31:0] wd);
    vec_t v;
    v.st = st; v.f3 = f3; v.a = a; v.sd = sd; v.err = err;
    v.data = data; v.lat = lat; v.wr = wr; v.wd = wd;
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    resp_t r;
    wr_t   w;
    r.err = v.err; r.data = v.data; r.lat = v.lat;
    exp_q.push_back(r);
    if (v.wr) begin
      w.adr  = {v.a[31:2], 2'b00};
      w.data = v.wd;
      wexp_q.push_back(w);
    end
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || wexp_q.size() != 0) && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check({name, "_resp_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_write_drained"}, 32'(wexp_q.size()), 32'd0);
  endtask

  task automatic issue(input string name, input vec_t v);
    int waited;
    push_exp(v);
    isStore = v.st; funct3 = v.f3; addr = v.a; storeData = v.sd; reqValid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!reqReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_accepted"}, 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    reqValid = 1'b0;
    drain(name);
  endtask

  // Monitor: compares every response and every memory write against the queues.
  resp_t mon_e;
  wr_t   mon_w;
  int    mon_a;
  always @(negedge clk) begin
    if (!rstN) begin
      acc_q.delete();
    end else begin
      if (reqValid && reqReady) acc_q.push_back(cycle);
      if (respValid) begin
        check("resp_expected", 32'(exp_q.size() != 0 && acc_q.size() != 0), 32'd1);
        if (exp_q.size() != 0 && acc_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          mon_a = acc_q.pop_front();
          check("respErr", 32'(respErr), 32'(mon_e.err));
          check("loadData", loadData, mon_e.data);
          check("resp_latency", cycle - mon_a, mon_e.lat);
        end
      end
      if (memWrite) begin
        check("write_expected", 32'(wexp_q.size() != 0), 32'd1);
        if (wexp_q.size() != 0) begin
          mon_w = wexp_q.pop_front();
          check("memAdr", memAdr, mon_w.adr);
          check("writeData", writeData, mon_w.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  vec_t sv [4];
  int   idx;

  initial begin
    rstN = 1'b0; reqValid = 1'b0; isStore = 1'b0; funct3 = 3'b0;
    addr = 32'h0; storeData = 32'h0; mem_load = 1'b1;
    @(posedge clk); #1;
    mem_load = 1'b0;
    @(negedge clk);
    check("rst_reqReady", 32'(reqReady), 32'd0);
    check("rst_memWrite", 32'(memWrite), 32'd0);
    check("rst_respValid", 32'(respValid), 32'd0);
    check("rst_respErr", 32'(respErr), 32'd0);
    check("rst_loadData", loadData, 32'h0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(reqReady), 32'd1);
    @(posedge clk); #1;

    // Loads from word 0x100 = 0x8899AABB and from the last word of memory.
    issue("lb_101",   mk(1'b0, 3'b000, 32'h101,  32'h0, 1'b0, 32'hFFFFFF99, 2, 1'b0, 32'h0));
    issue("lbu_103",  mk(1'b0, 3'b100, 32'h103,  32'h0, 1'b0, 32'h000000BB, 2, 1'b0, 32'h0));
    issue("lh_100",   mk(1'b0, 3'b001, 32'h100,  32'h0, 1'b0, 32'hFFFF8899, 2, 1'b0, 32'h0));
    issue("lhu_102",  mk(1'b0, 3'b101, 32'h102,  32'h0, 1'b0, 32'h0000AABB, 2, 1'b0, 32'h0));
    issue("lw_100",   mk(1'b0, 3'b010, 32'h100,  32'h0, 1'b0, 32'h8899AABB, 2, 1'b0, 32'h0));
    issue("lb_100",   mk(1'b0, 3'b000, 32'h100,  32'h0, 1'b0, 32'hFFFFFF88, 2, 1'b0, 32'h0));
    issue("lh_102",   mk(1'b0, 3'b001, 32'h102,  32'h0, 1'b0, 32'hFFFFAABB, 2, 1'b0, 32'h0));
    issue("lw_fffc",  mk(1'b0, 3'b010, 32'hFFFC, 32'h0, 1'b0, 32'hCAFEF00D, 2, 1'b0, 32'h0));
    issue("lhu_fffe", mk(1'b0, 3'b101, 32'hFFFE, 32'h0, 1'b0, 32'h0000F00D, 2, 1'b0, 32'h0));
    issue("lb_ffff",  mk(1'b0, 3'b000, 32'hFFFF, 32'h0, 1'b0, 32'h0000000D, 2, 1'b0, 32'h0));

    // SH 0x100 aborted by reset during its WRITE cycle.
    isStore = 1'b1; funct3 = 3'b001; addr = 32'h100; storeData = 32'h0000CAFE; reqValid = 1'b1;
    @(negedge clk);
    check("abort_accept", 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b0;
    @(negedge clk);
    check("abort_memWrite", 32'(memWrite), 32'd0);
    check("abort_reqReady", 32'(reqReady), 32'd0);
    check("abort_respValid", 32'(respValid), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    check("abort_ready_after", 32'(reqReady), 32'd1);
    check("abort_loadData", loadData, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_word_kept", mem[14'h0040], 32'h8899AABB);

    // Stores: byte and halfword merges, full word, read-back.
    issue("sb_102",  mk(1'b1, 3'b000, 32'h102, 32'h12345677, 1'b0, 32'h0, 3, 1'b1, 32'h889977BB));
    issue("lw_after_sb", mk(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h889977BB, 2, 1'b0, 32'h0));
    issue("sh_102",  mk(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 1'b0, 32'h0, 3, 1'b1, 32'h8899BEEF));
    issue("sh_100",  mk(1'b1, 3'b001, 32'h100, 32'hFFFF1234, 1'b0, 32'h0, 3, 1'b1, 32'h1234BEEF));
    issue("sb_103",  mk(1'b1, 3'b000, 32'h103, 32'h00000042, 1'b0, 32'h0, 3, 1'b1, 32'h1234BE42));
    issue("sw_104",  mk(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1'b1, 32'hDEADBEEF));
    issue("lw_104",  mk(1'b0, 3'b010, 32'h104, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1'b0, 32'h0));
    check("mem_100_final", mem[14'h0040], 32'h1234BE42);

    // Rejected requests: no access, loadData cleared, one-cycle latency.
    issue("err_lw_102",  mk(1'b0, 3'b010, 32'h102,   32'h0, 1'b1, 32'h0, 1, 1'b0, 32'h0));
    issue("err_sh_101",  mk(1'b1, 3'b001, 32'h101,   32'h5555, 1'b1, 32'h0, 1, 1'b0, 32'h0));
    issue("err_f3_011",  mk(1'b0, 3'b011, 32'h100,   32'h0, 1'b1, 32'h0, 1, 1'b0, 32'h0));
    issue("err_sw_10000", mk(1'b1, 3'b010, 32'h10000, 32'h1, 1'b1, 32'h0, 1, 1'b0, 32'h0));
    issue("err_lb_10000", mk(1'b0, 3'b000, 32'h10000, 32'h0, 1'b1, 32'h0, 1, 1'b0, 32'h0));
    issue("err_lhu_ffff", mk(1'b0, 3'b101, 32'hFFFF,  32'h0, 1'b1, 32'h0, 1, 1'b0, 32'h0));
    issue("err_st_f3_100", mk(1'b1, 3'b100, 32'h100,  32'h7, 1'b1, 32'h0, 1, 1'b0, 32'h0));
    check("mem_100_after_err", mem[14'h0040], 32'h1234BE42);
    check("mem_10000_wrap", mem[14'h0000], 32'h0);

    // reqValid held for 10 cycles, alternating LW / SB on word 0x108.
    sv[0] = mk(1'b0, 3'b010, 32'h108, 32'h0,  1'b0, 32'h11223344, 2, 1'b0, 32'h0);
    sv[1] = mk(1'b1, 3'b000, 32'h109, 32'hA5, 1'b0, 32'h0,        3, 1'b1, 32'h11A53344);
    sv[2] = mk(1'b0, 3'b010, 32'h108, 32'h0,  1'b0, 32'h11A53344, 2, 1'b0, 32'h0);
    sv[3] = mk(1'b1, 3'b000, 32'h10B, 32'h5A, 1'b0, 32'h0,        3, 1'b1, 32'h11A5335A);
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 4) begin
        isStore = sv[idx].st; funct3 = sv[idx].f3; addr = sv[idx].a;
        storeData = sv[idx].sd; reqValid = 1'b1;
      end else begin
        reqValid = 1'b0;
      end
      @(negedge clk);
      if (reqValid && reqReady) begin
        push_exp(sv[idx]);
        idx++;
      end
      @(posedge clk); #1;
    end
    reqValid = 1'b0;
    check("stream_accepts", idx, 3);
    drain("stream");
    check("mem_108_final", mem[14'h0042], 32'h11A53344);

    repeat (4) @(posedge clk);
    #1;
    check("final_resp_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_write_q_empty", 32'(wexp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_BYTES, default 65536: data memory size in bytes; byte addresses >= MEM_BYTES are out of range.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rstN  input  1  reset; synchronous, active-low.
REQ-004 reqValid  input  1  core presents a memory request.
REQ-005 reqReady  output  1  unit idle, request accepted this cycle if reqValid=1.
REQ-006 isStore  input  1  1=store, 0=load.
REQ-007 funct3  input  3  RV32I width/sign code.
REQ-008 addr  input  32  byte address.
REQ-009 storeData  input  32  store source; the relevant bytes are taken from the LSBs.
REQ-010 respValid  output  1  one-cycle completion pulse.
REQ-011 respErr  output  1  qualifies respValid; request rejected.
REQ-012 loadData  output  32  extended load result, valid with respValid.
REQ-013 memAdr  output  32  word address to data memory.
REQ-014 writeData  output  32  merged word to data memory.
REQ-015 memWrite  output  1  data memory write enable.
REQ-016 readData  input  32  combinational read word from data memory at memAdr.

Function
REQ-017 Byte order SHALL be big-endian: byte offset k (addr[1:0]=k) occupies word bits [31-8k:24-8k]; halfword offset 0 occupies [31:16] and offset 2 occupies [15:0].
REQ-018 The request SHALL be accepted only when reqValid=1 and reqReady=1; isStore, funct3, addr and storeData SHALL be registered at acceptance.
REQ-019 reqReady SHALL be 1 only in state IDLE.
REQ-020 States SHALL be IDLE, READ, WRITE and DONE.
- Load: IDLE->READ->DONE.
- SB/SH: IDLE->READ->WRITE->DONE.
- SW: IDLE->WRITE->DONE.
- Error: IDLE->DONE.
- DONE->IDLE unconditionally.
REQ-021 Loads SHALL use funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores SHALL use funct3 000 SB, 001 SH, 010 SW.
REQ-022 Any other funct3, a misaligned access (halfword addr[0]=1, word addr[1:0]!=0), or addr+size > MEM_BYTES SHALL be an error: no memory access and no memWrite.
REQ-023 memAdr SHALL equal {addr_r[31:2],2'b00} in READ and WRITE, and 0 in IDLE and DONE.
REQ-024 In READ, readData SHALL be captured at the closing edge; loads SHALL extract the addressed lane, sign-extend for LB/LH, zero-extend for LBU/LHU, or pass the word for LW.
REQ-025 For SB/SH, writeData in WRITE SHALL equal the captured word with only the addressed lane replaced by storeData[7:0] or storeData[15:0]; for SW it SHALL equal storeData.
REQ-026 memWrite SHALL be (state==WRITE) AND rstN, asserted exactly one cycle per store.
REQ-027 respValid SHALL be 1 only in DONE; loadData and respErr SHALL be held stable in DONE.
- loadData SHALL be 0 for stores and for errors.
REQ-028 respValid SHALL follow acceptance by 2 cycles (load, SW), 3 cycles (SB/SH) or 1 cycle (error).
REQ-029 A reqValid held high through DONE SHALL NOT be accepted until the following IDLE cycle.

Reset
REQ-030 When rstN=0 at a posedge, the state SHALL become IDLE, and respValid, respErr, loadData and all registered request fields SHALL become 0.
REQ-031 While rstN=0, memWrite SHALL be 0 and reqReady SHALL be 0; reset in any state SHALL abort the operation with no response pulse.
REQ-032 On the first cycle after rstN returns to 1, reqReady SHALL be 1.

Verification
REQ-033 Memory word 0x100 = 0x8899AABB:
- LB 0x101 -> loadData 0xFFFFFF99, respValid 2 cycles after accept.
- LBU 0x103 -> 0x000000BB.
- LH 0x100 -> 0xFFFF8899.
- LHU 0x102 -> 0x0000AABB.
REQ-034 SB 0x102, storeData 0x12345677 -> exactly one memWrite cycle with writeData 0x889977BB, respValid 3 cycles after accept, respErr=0.
REQ-035 SW 0x104, storeData 0xDEADBEEF -> memWrite one cycle with memAdr 0x104; a following LW 0x104 returns 0xDEADBEEF.
REQ-036 Error cases -> respValid+respErr 1 cycle after accept, memWrite never 1, loadData 0:
- LW 0x102.
- SH 0x101.
- funct3 011 load.
- SW 0x10000 with MEM_BYTES=65536.
REQ-037 SH 0x100 with rstN pulled low during the WRITE cycle -> memWrite 0, word stays 0x8899AABB, no respValid, reqReady=1 on the cycle after rstN returns high.
REQ-038 reqValid held high for 10 cycles with alternating LW/SB -> each request accepted only in IDLE cycles, one respValid per accepted request, no request lost or duplicated.
